accumulate_8bit: RTL and testbench

Sequential accumulator that sums a frame of NUM_OPERANDS 8-bit operands, streamed in over a valid/ready handshake, into one 8-bit result with a sticky overflow flag. It is the control and register stage that feeds adder_8bit. Each accepted operand goes to the adder's b input, and the running total goes to its a input. The registered sum is then offered to the downstream consumer over a valid/ready handshake.

---
 rtl/accumulate_pkg.sv | 14 +
 rtl/adder_8bit.sv | 22 ++
 rtl/accumulate_8bit.sv | 101 ++++++++++
 tb/tb_accumulate_8bit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/accumulate_pkg.sv
// Shared types and constants for the frame accumulator.
//   DATA_WIDTH : operand / result width in bits
//   state_e    : control FSM state encoding (idle, accumulating, result held)
package accumulate_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/adder_8bit.sv
// Combinational unsigned adder with carry in and carry out.
//   a, b      : addends
//   carry_in  : carry into bit 0
//   sum       : (a + b + carry_in) modulo 2^DATA_WIDTH
//   overflow  : carry out of the top bit
module adder_8bit
  import accumulate_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  overflow
);

  logic [DATA_WIDTH:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, carry_in};
  assign sum      = full[DATA_WIDTH-1:0];
  assign overflow = full[DATA_WIDTH];

endmodule

// File: rtl/accumulate_8bit.sv
// Frame accumulator: sums NUM_OPERANDS operands taken over a valid/ready
// handshake and offers the wrapped sum plus a sticky carry flag downstream.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a frame (only honoured when idle)
//   in_valid/in_ready : operand handshake, in_data is the operand
//   out_valid/out_ready : result handshake, out_sum/out_overflow is the result
//   busy              : high whenever a frame is in progress or held
module accumulate_8bit
  import accumulate_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_overflow,
  output logic                  busy
);

  localparam int unsigned CntWidth = $clog2(NUM_OPERANDS + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NUM_OPERANDS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_ovf;

  adder_8bit u_adder (
    .a        (acc_q),
    .b        (in_data),
    .carry_in (1'b0),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAccum;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StAccum: begin
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          // Counter parks at the last index so it never exceeds NUM_OPERANDS-1.
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs depend on state only.
  assign in_ready     = (state_q == StAccum);
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_accumulate_8bit.sv
// Self-checking bench for accumulate_8bit: a 4-operand instance for the
// handshake/timing scenarios and a 2-operand instance for pairwise sums.
module tb_accumulate_8bit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 4-operand instance
  logic       a_start = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [7:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid, a_out_overflow, a_busy;
  logic [7:0] a_out_sum;

  // 2-operand instance
  logic       b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid, b_out_overflow, b_busy;
  logic [7:0] b_out_sum;

  accumulate_8bit #(.NUM_OPERANDS(4)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .start        (a_start),
    .in_valid     (a_in_valid),
    .in_data      (a_in_data),
    .in_ready     (a_in_ready),
    .out_valid    (a_out_valid),
    .out_ready    (a_out_ready),
    .out_sum      (a_out_sum),
    .out_overflow (a_out_overflow),
    .busy         (a_busy)
  );

  accumulate_8bit #(.NUM_OPERANDS(2)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .start        (b_start),
    .in_valid     (b_in_valid),
    .in_data      (b_in_data),
    .in_ready     (b_in_ready),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .out_sum      (b_out_sum),
    .out_overflow (b_out_overflow),
    .busy         (b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ops_a [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame on the 4-operand instance using ops_a. Expected results come
  // from the true integer sum: wrapped value and whether it ever passed 255.
  task automatic frame_a(input int gap, input int hold, input bit poke_start);
    int total = 0;
    int partial = 0;
    for (int i = 0; i < 4; i++) total += int'(ops_a[i]);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start_in_ready", 32'(a_in_ready), 1);
    check("start_busy", 32'(a_busy), 1);
    check("start_out_valid", 32'(a_out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = ops_a[i];
      tick();
      a_in_valid = 1'b0;
      a_in_data  = 8'($urandom);
      partial += int'(ops_a[i]);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          check("gap_in_ready", 32'(a_in_ready), 1);
          check("gap_acc_hold", 32'(a_out_sum), 32'(partial % 256));
          tick();
        end
        check("accum_out_valid", 32'(a_out_valid), 0);
      end
    end
    check("done_out_valid", 32'(a_out_valid), 1);
    check("done_in_ready", 32'(a_in_ready), 0);
    check("done_sum", 32'(a_out_sum), 32'(total % 256));
    check("done_ovf", 32'(a_out_overflow), 32'(total > 255));
    for (int h = 0; h < hold; h++) begin
      a_out_ready = 1'b0;
      a_start     = poke_start && (h % 2 == 0);
      tick();
      a_start = 1'b0;
      check("hold_out_valid", 32'(a_out_valid), 1);
      check("hold_sum", 32'(a_out_sum), 32'(total % 256));
      check("hold_ovf", 32'(a_out_overflow), 32'(total > 255));
      check("hold_in_ready", 32'(a_in_ready), 0);
    end
    a_out_ready = 1'b1;
    a_start     = poke_start;
    tick();
    a_out_ready = 1'b0;
    a_start     = 1'b0;
    check("handoff_out_valid", 32'(a_out_valid), 0);
    check("handoff_busy", 32'(a_busy), 0);
    tick();
    check("idle_busy", 32'(a_busy), 0);
    check("idle_in_ready", 32'(a_in_ready), 0);
  endtask

  task automatic frame_b(input logic [7:0] x, input logic [7:0] y);
    int total = int'(x) + int'(y);
    b_start = 1'b1;
    tick();
    b_start    = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = x;
    tick();
    b_in_data = y;
    tick();
    b_in_valid = 1'b0;
    check("pair_valid", 32'(b_out_valid), 1);
    check("pair_sum", 32'(b_out_sum), 32'(total % 256));
    check("pair_ovf", 32'(b_out_overflow), 32'(total > 255));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic set_ops(input int o0, input int o1, input int o2, input int o3);
    ops_a[0] = 8'(o0);
    ops_a[1] = 8'(o1);
    ops_a[2] = 8'(o2);
    ops_a[3] = 8'(o3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(a_in_ready), 0);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_sum", 32'(a_out_sum), 0);
    check("rst_ovf", 32'(a_out_overflow), 0);
    check("rst_busy", 32'(a_busy), 0);
    rst = 1'b0;
    tick();

    set_ops(1, 2, 3, 4);
    frame_a(0, 0, 1'b0);
    set_ops(200, 100, 0, 0);
    frame_a(0, 1, 1'b0);
    set_ops(255, 1, 0, 0);
    frame_a(0, 0, 1'b0);
    set_ops(5, 6, 7, 8);
    frame_a(3, 0, 1'b0);
    set_ops(250, 250, 250, 250);
    frame_a(1, 5, 1'b1);
    set_ops(9, 9, 9, 9);
    frame_a(0, 0, 1'b0);

    // Reset in the middle of a frame after two accepts.
    a_start = 1'b1;
    tick();
    a_start    = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = 8'd100;
    tick();
    a_in_data = 8'd120;
    tick();
    a_in_data = 8'd90;
    #3;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(a_in_ready), 0);
    check("midrst_out_valid", 32'(a_out_valid), 0);
    check("midrst_sum", 32'(a_out_sum), 0);
    check("midrst_ovf", 32'(a_out_overflow), 0);
    check("midrst_busy", 32'(a_busy), 0);
    tick();
    rst        = 1'b0;
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_valid", 32'(a_out_valid), 0);
      check("midrst_idle", 32'(a_busy), 0);
    end
    set_ops(1, 1, 1, 1);
    frame_a(0, 0, 1'b0);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 4; i++) ops_a[i] = 8'($urandom);
      frame_a(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    frame_b(8'd0, 8'd0);
    frame_b(8'd255, 8'd1);
    frame_b(8'd128, 8'd128);
    frame_b(8'd255, 8'd255);
    frame_b(8'd127, 8'd128);
    for (int k = 0; k < 1500; k++) begin
      frame_b(8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
